// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch / IR block.
// Used by ifetch_ir and pc_next_sel.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_VALID = 2'b01,
        S_FAULT = 2'b10
    } state_e;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OPC_LSB = 2;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_BIT  = 30;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_ir_pc_next_sel.sv
// Next-PC selection: sequential (+4, wrapping), branch or jump target,
// always returned word-aligned.
module pc_next_sel
    import ifetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_source_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] next_pc_o
);

    // Select the next fetch address from the control-unit source code
    always_comb begin
        next_pc_o = word_align(pc_i + 32'd4);
        case (pc_source_i)
            PCS_SEQ:        next_pc_o = word_align(pc_i + 32'd4);
            PCS_BR:         next_pc_o = word_align(branch_target_i);
            PCS_JMP, 2'b11: next_pc_o = word_align(jump_target_i);
            default:        next_pc_o = word_align(jump_target_i);
        endcase
    end

endmodule

// File: rtl/ifetch_ir.sv
// Instruction fetch FSM with PC and instruction register.
// Optional fetch watchdog enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_ir
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCEN,
    input  logic [1:0]  PCSource,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] mem_data_in,
    input  logic        MIO_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] IR,
    output logic [4:0]  OPcode,
    output logic [2:0]  Fun3,
    output logic        Fun7,
    output logic [31:0] PC_out,
    output logic        inst_valid,
    output logic        ill_inst,
    output logic        ifault
);

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ifetch_ir: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] next_pc_s;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    pc_next_sel u_pc_next_sel (
        .pc_i            (pc_q),
        .pc_source_i     (PCSource),
        .branch_target_i (branch_target),
        .jump_target_i   (jump_target),
        .next_pc_o       (next_pc_s)
    );

    // State, PC and IR registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            ir_q     <= NOP_INST;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state logic: fetch on MIO_ready, advance on PCEN, all else held
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_REQ: begin
                if (MIO_ready) begin
                    ir_d     = mem_data_in;
                    pc_out_d = pc_q;
                    state_d  = S_VALID;
`ifdef IFETCH_TIMEOUT_EN
                    cnt_d    = 8'd0;
`endif
                end else begin
`ifdef IFETCH_TIMEOUT_EN
                    if (cnt_q == TMO_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_VALID: begin
                if (PCEN) begin
                    pc_d    = next_pc_s;
                    state_d = S_REQ;
`ifdef IFETCH_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    state_d = S_VALID;
                end
            end
            default: begin
                // Fault is terminal when the watchdog exists; otherwise an
                // unexpected encoding recovers by refetching.
`ifdef IFETCH_TIMEOUT_EN
                state_d = S_FAULT;
`else
                state_d = S_REQ;
`endif
            end
        endcase
    end

    assign mem_req    = (state_q == S_REQ);
    assign inst_valid = (state_q == S_VALID);
    assign mem_addr   = pc_q;
    assign IR         = ir_q;
    assign PC_out     = pc_out_q;
    assign OPcode     = ir_q[OPC_MSB:OPC_LSB];
    assign Fun3       = ir_q[F3_MSB:F3_LSB];
    assign Fun7       = ir_q[F7_BIT];
    assign ill_inst   = inst_valid && (ir_q[1:0] != 2'b11);

`ifdef IFETCH_TIMEOUT_EN
    assign ifault = (state_q == S_FAULT);
`else
    assign ifault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ir.sv
// Self-checking bench for ifetch_ir: abstract fetch model compared every
// cycle, plus hand-computed literal checks at key points.
module tb_ifetch_ir;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          TMO     = 255;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCEN;
    logic [1:0]  PCSource;
    logic [31:0] branch_target, jump_target, mem_data_in;
    logic        MIO_ready;
    logic        mem_req, inst_valid, ill_inst, ifault, Fun7;
    logic [31:0] mem_addr, IR, PC_out;
    logic [4:0]  OPcode;
    logic [2:0]  Fun3;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_ir #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .PCEN(PCEN), .PCSource(PCSource),
        .branch_target(branch_target), .jump_target(jump_target),
        .mem_data_in(mem_data_in), .MIO_ready(MIO_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .IR(IR), .OPcode(OPcode),
        .Fun3(Fun3), .Fun7(Fun7), .PC_out(PC_out), .inst_valid(inst_valid),
        .ill_inst(ill_inst), .ifault(ifault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Abstract model: "holding an instruction" flag, fetch address,
    // captured word and its address, stall count and fault flag.
    logic [31:0] m_pc, m_ir, m_pcout;
    logic        m_hold, m_fault;
    int          m_wait;

    function automatic logic [31:0] target(input logic [1:0] src, input logic [31:0] pc,
                                           input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] t;
        if (src == 2'd0)      t = pc + 32'd4;
        else if (src == 2'd1) t = bt;
        else                  t = jt;
        return t & 32'hFFFF_FFFC;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= RST_PC; m_ir <= NOP; m_pcout <= RST_PC;
            m_hold <= 1'b0; m_fault <= 1'b0; m_wait <= 0;
        end else if (!m_fault) begin
            if (!m_hold) begin
                if (MIO_ready) begin
                    m_ir <= mem_data_in; m_pcout <= m_pc; m_hold <= 1'b1; m_wait <= 0;
                end else begin
                    m_wait <= m_wait + 1;
`ifdef IFETCH_TIMEOUT_EN
                    if (m_wait + 1 >= TMO) m_fault <= 1'b1;
`endif
                end
            end else if (PCEN) begin
                m_pc   <= target(PCSource, m_pc, branch_target, jump_target);
                m_hold <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mem_req", {31'd0, mem_req}, {31'd0, !m_hold && !m_fault});
            if (!m_hold && !m_fault) chk("mem_addr", mem_addr, m_pc);
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold && !m_fault});
            chk("IR", IR, m_ir);
            chk("PC_out", PC_out, m_pcout);
            chk("OPcode", {27'd0, OPcode}, {27'd0, m_ir[6:2]});
            chk("Fun3", {29'd0, Fun3}, {29'd0, m_ir[14:12]});
            chk("Fun7", {31'd0, Fun7}, {31'd0, m_ir[30]});
            chk("ill_inst", {31'd0, ill_inst}, {31'd0, m_hold && !m_fault && (m_ir[1:0] != 2'b11)});
            chk("ifault", {31'd0, ifault}, {31'd0, m_fault});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        MIO_ready = 1'b1; mem_data_in = d;
        cyc();
        MIO_ready = 1'b0;
    endtask

    task automatic advance(input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
        PCSource = src; branch_target = bt; jump_target = jt; PCEN = 1'b1;
        cyc();
        PCEN = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PCEN = 1'b0; PCSource = 2'd0; branch_target = 32'd0;
        jump_target = 32'd0; mem_data_in = 32'd0; MIO_ready = 1'b0;
        #1;
        chk("rst_IR", IR, 32'h0000_0013);
        chk("rst_PC_out", PC_out, 32'h0000_0000);
        chk("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("rst_ifault", {31'd0, ifault}, 32'd0);
        #11;
        reset = 1'b0; MIO_ready = 1'b1; mem_data_in = 32'h0073_02B3;
        #1;
        chk("first_mem_addr", mem_addr, 32'h0000_0000);
        chk("first_mem_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        MIO_ready = 1'b0;
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("first_opcode", {27'd0, OPcode}, 32'h0000_000C);
        chk("first_fun3", {29'd0, Fun3}, 32'd0);
        chk("first_fun7", {31'd0, Fun7}, 32'd0);

        advance(2'd0, 32'd0, 32'd0); fetch(32'h0010_0093);
        advance(2'd0, 32'd0, 32'd0); fetch(32'h0020_8113);
        advance(2'd0, 32'd0, 32'd0); fetch(32'h0031_0193);
        advance(2'd0, 32'd0, 32'd0); fetch(32'h4020_8233);
        chk("sub_fun7", {31'd0, Fun7}, 32'd1);
        chk("sub_pc_out", PC_out, 32'h0000_0010);

        advance(2'd1, 32'h0000_0043, 32'h0000_0999);
        chk("branch_addr", mem_addr, 32'h0000_0040);
        chk("branch_req", {31'd0, mem_req}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            PCEN = i[0];
            cyc();
        end
        PCEN = 1'b0;
        chk("stall_addr", mem_addr, 32'h0000_0040);
        chk("stall_valid", {31'd0, inst_valid}, 32'd0);

        fetch(32'h0000_006F);
        MIO_ready = 1'b1; mem_data_in = 32'hDEAD_BEEF;
        cyc(); cyc(); cyc();
        MIO_ready = 1'b0;
        chk("hold_IR", IR, 32'h0000_006F);

        advance(2'd3, 32'd0, 32'h0000_1003);
        chk("jmp11_addr", mem_addr, 32'h0000_1000);
        fetch(32'h0000_0013);
        advance(2'd2, 32'd0, 32'hFFFF_FFFE);
        chk("jmp_top_addr", mem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        advance(2'd0, 32'd0, 32'd0);
        chk("wrap_addr", mem_addr, 32'h0000_0000);
        fetch(32'h0000_0000);
        chk("ill_inst_zero", {31'd0, ill_inst}, 32'd1);

        advance(2'd1, 32'h0000_0020, 32'd0);
        fetch(32'h0050_0093);
        chk("pre_rst_pc_out", PC_out, 32'h0000_0020);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_IR", IR, 32'h0000_0013);
        chk("mid_rst_PC_out", PC_out, 32'h0000_0000);
        chk("mid_rst_addr", mem_addr, 32'h0000_0000);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_ifault", {31'd0, ifault}, 32'd0);
        cyc(); #2;
        reset = 1'b0;
        cyc();

`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < TMO + 5; i++) cyc();
        chk("tmo_ifault", {31'd0, ifault}, 32'd1);
        chk("tmo_mem_req", {31'd0, mem_req}, 32'd0);
        fetch(32'h0000_0013);
        chk("tmo_sticky", {31'd0, ifault}, 32'd1);
        chk("tmo_no_valid", {31'd0, inst_valid}, 32'd0);
        #2; reset = 1'b1; #1;
        chk("tmo_rst_clear", {31'd0, ifault}, 32'd0);
        #3; reset = 1'b0;
        cyc();
`else
        for (int i = 0; i < TMO + 45; i++) cyc();
        chk("no_tmo_ifault", {31'd0, ifault}, 32'd0);
        chk("no_tmo_req", {31'd0, mem_req}, 32'd1);
`endif
        fetch(32'h0000_0033);
        chk("final_valid", {31'd0, inst_valid}, 32'd1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
